// File: rtl/bitwise_acc.sv
// bitwise_acc -- registered bitwise logic co-unit with an optional accumulator.
//
// Computes one of eight bitwise functions of (x, b), where x is either operand
// a or the internal accumulator. The result goes through a single registered
// stage with valid/ready handshakes on both sides.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   in_valid  request carries valid op/a/b/acc_sel
//   in_ready  block can accept a request this cycle (combinational)
//   op        function select: AND, OR, XOR, NAND, NOR, XNOR, NOT x, pass b
//   acc_sel   1 = use the accumulator as operand x instead of a
//   a, b      WIDTH-bit operands
//   clr       synchronous accumulator clear (wins over a same-cycle accept)
//   out_valid out/zr/ng hold a valid result
//   out_ready consumer takes the result this cycle
//   out       registered result
//   zr        registered, 1 when out == 0
//   ng        registered, MSB of out
//   acc       current accumulator value (all zeros when ACC_EN = 0)
module bitwise_acc #(
  parameter int WIDTH  = 16,
  parameter bit ACC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic [WIDTH-1:0] acc
);

  function automatic logic [WIDTH-1:0] bit_fn(
    input logic [2:0]       f,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    case (f)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = x ^ y;
      3'b011:  r = ~(x & y);
      3'b100:  r = ~(x | y);
      3'b101:  r = ~(x ^ y);
      3'b110:  r = ~x;
      default: r = y;
    endcase
    return r;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             accept;
  logic [WIDTH-1:0] x_sel;
  logic [WIDTH-1:0] res;

  // Input side: operand select and function evaluation
  always_comb begin
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;
    x_sel    = (ACC_EN && acc_sel) ? acc_q : a;
    res      = bit_fn(op, x_sel, b);

    out_valid_d = out_valid_q;
    out_d       = out_q;
    zr_d        = zr_q;
    ng_d        = ng_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_d       = res;
      zr_d        = (res == '0);
      ng_d        = res[WIDTH-1];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // With ACC_EN = 0 this is constant zero, so the acc flops fold away.
    // clr takes priority; the same-cycle result above still used the old acc.
    acc_d = acc_q;
    if (!ACC_EN || clr) begin
      acc_d = '0;
    end else if (accept) begin
      acc_d = res;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zr_q        <= 1'b1;
      ng_q        <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zr_q        <= zr_d;
      ng_q        <= ng_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_bitwise_acc.sv
module tb_bitwise_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, acc_sel, clr, out_valid, out_ready, zr, ng;
  logic [2:0]  op;
  logic [15:0] a, b, out, acc;

  logic        in_valid8, in_ready8, acc_sel8, clr8, out_valid8, out_ready8, zr8, ng8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, out8, acc8;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  bitwise_acc #(.WIDTH(16), .ACC_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_sel(acc_sel), .a(a), .b(b), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .zr(zr),
    .ng(ng), .acc(acc)
  );

  bitwise_acc #(.WIDTH(8), .ACC_EN(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .acc_sel(acc_sel8), .a(a8), .b(b8), .clr(clr8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out(out8), .zr(zr8),
    .ng(ng8), .acc(acc8)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic [15:0] eo, input logic ez,
                         input logic en, input logic [15:0] ea);
    chk({tag, ".valid"}, {15'd0, out_valid}, 16'd1);
    chk({tag, ".out"},   out, eo);
    chk({tag, ".zr"},    {15'd0, zr}, {15'd0, ez});
    chk({tag, ".ng"},    {15'd0, ng}, {15'd0, en});
    chk({tag, ".acc"},   acc, ea);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0; acc_sel = 1'b0;
    op = 3'd0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; clr8 = 1'b0; acc_sel8 = 1'b0;
    op8 = 3'd0; a8 = '0; b8 = '0;
    tick(); tick();

    // Reset state
    chk("rst.valid", {15'd0, out_valid}, 16'd0);
    chk("rst.out", out, 16'h0000);
    chk("rst.zr", {15'd0, zr}, 16'd1);
    chk("rst.ng", {15'd0, ng}, 16'd0);
    chk("rst.acc", acc, 16'h0000);
    chk("rst.in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst.acc8", {8'd0, acc8}, 16'h0000);

    // First transaction
    rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1; a = 16'hFFFF; b = 16'h0000; op = 3'b000;
    tick(); chk_res("and0", 16'h0000, 1'b1, 1'b0, 16'h0000);

    a = 16'hAAAA; b = 16'hFFFF; op = 3'b000;
    tick(); chk_res("andA", 16'hAAAA, 1'b0, 1'b1, 16'hAAAA);

    // All opcodes on CCCC / AAAA, back to back
    a = 16'hCCCC; b = 16'hAAAA;
    op = 3'b000; tick(); chk_res("and",  16'h8888, 1'b0, 1'b1, 16'h8888);
    op = 3'b001; tick(); chk_res("or",   16'hEEEE, 1'b0, 1'b1, 16'hEEEE);
    op = 3'b010; tick(); chk_res("xor",  16'h6666, 1'b0, 1'b0, 16'h6666);
    op = 3'b011; tick(); chk_res("nand", 16'h7777, 1'b0, 1'b0, 16'h7777);
    op = 3'b100; tick(); chk_res("nor",  16'h1111, 1'b0, 1'b0, 16'h1111);
    op = 3'b101; tick(); chk_res("xnor", 16'h9999, 1'b0, 1'b1, 16'h9999);
    op = 3'b110; tick(); chk_res("notx", 16'h3333, 1'b0, 1'b0, 16'h3333);
    op = 3'b111; tick(); chk_res("passb", 16'hAAAA, 1'b0, 1'b1, 16'hAAAA);

    // Backpressure
    a = 16'h00FF; b = 16'h0F0F; op = 3'b001;
    tick(); chk_res("bp.first", 16'h0FFF, 1'b0, 1'b0, 16'h0FFF);
    out_ready = 1'b0; a = 16'h1234; b = 16'h5678; op = 3'b111;
    #1;
    chk("bp.in_ready_low", {15'd0, in_ready}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp.hold.out", out, 16'h0FFF);
      chk("bp.hold.valid", {15'd0, out_valid}, 16'd1);
      chk("bp.hold.in_ready", {15'd0, in_ready}, 16'd0);
      chk("bp.hold.acc", acc, 16'h0FFF);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_high", {15'd0, in_ready}, 16'd1);
    tick(); chk_res("bp.next", 16'h5678, 1'b0, 1'b0, 16'h5678);
    in_valid = 1'b0;
    tick();
    chk("drain.valid", {15'd0, out_valid}, 16'd0);
    chk("drain.out", out, 16'h5678);

    // Accumulator chain
    clr = 1'b1;
    tick(); chk("clr.acc", acc, 16'h0000);
    chk("clr.valid", {15'd0, out_valid}, 16'd0);
    clr = 1'b0; in_valid = 1'b1; acc_sel = 1'b1; op = 3'b001; a = 16'hFFFF;
    b = 16'h0001; tick(); chk_res("chain1", 16'h0001, 1'b0, 1'b0, 16'h0001);
    b = 16'h0002; tick(); chk_res("chain2", 16'h0003, 1'b0, 1'b0, 16'h0003);
    b = 16'h0004; tick(); chk_res("chain3", 16'h0007, 1'b0, 1'b0, 16'h0007);

    // clr together with accept: result from old acc, acc cleared
    clr = 1'b1; op = 3'b010; b = 16'h0003;
    tick(); chk_res("clracc", 16'h0004, 1'b0, 1'b0, 16'h0000);
    clr = 1'b0;

    // Mid-operation reset
    acc_sel = 1'b0; a = 16'hF0F0; b = 16'hFFFF; op = 3'b000;
    tick(); chk_res("mid.load", 16'hF0F0, 1'b0, 1'b1, 16'hF0F0);
    out_ready = 1'b0; in_valid = 1'b0;
    tick(); chk("mid.held", out, 16'hF0F0);
    rst_n = 1'b0;
    tick();
    chk("mid.rst.valid", {15'd0, out_valid}, 16'd0);
    chk("mid.rst.out", out, 16'h0000);
    chk("mid.rst.zr", {15'd0, zr}, 16'd1);
    chk("mid.rst.acc", acc, 16'h0000);
    rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 16'h0F00; b = 16'hFF00; op = 3'b000;
    tick(); chk_res("mid.after", 16'h0F00, 1'b0, 1'b0, 16'h0F00);
    in_valid = 1'b0;
    tick();

    // WIDTH=8, no accumulator: acc_sel ignored, clr ignored
    in_valid8 = 1'b1; acc_sel8 = 1'b1; clr8 = 1'b1; a8 = 8'h3C; b8 = 8'h0F; op8 = 3'b000;
    tick();
    chk("w8.valid", {15'd0, out_valid8}, 16'd1);
    chk("w8.and", {8'd0, out8}, 16'h000C);
    chk("w8.acc", {8'd0, acc8}, 16'h0000);
    op8 = 3'b110; clr8 = 1'b0;
    tick();
    chk("w8.not", {8'd0, out8}, 16'h00C3);
    chk("w8.ng", {15'd0, ng8}, 16'd1);
    chk("w8.zr", {15'd0, zr8}, 16'd0);
    chk("w8.acc2", {8'd0, acc8}, 16'h0000);
    in_valid8 = 1'b0;
    tick();
    chk("w8.drain", {15'd0, out_valid8}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
